// File: rtl/bsg_reset_sequencer.sv
// rtl/bsg_reset_sequencer.sv - staged per-domain reset release with re-reset request port
// Holds selected domains in reset, then releases them lowest index first at fixed spacing.
module bsg_reset_sequencer #(
    parameter int num_domains_p = 4,
    parameter int hold_cycles_p = 16,
    parameter int gap_cycles_p  = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic [num_domains_p-1:0] mask_i,
    output logic                     ready_o,
    output logic [num_domains_p-1:0] async_reset_o,
    output logic                     done_o
);

    localparam int max_cycles_lp = (hold_cycles_p > gap_cycles_p) ? hold_cycles_p : gap_cycles_p;
    localparam int cnt_w_lp      = $clog2(max_cycles_lp + 1);

    localparam logic [cnt_w_lp-1:0] hold_last_lp = cnt_w_lp'(hold_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] gap_last_lp  = cnt_w_lp'(gap_cycles_p - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [cnt_w_lp-1:0]      cnt_q, cnt_d;
    logic [num_domains_p-1:0] pend_q, pend_d;
    logic [num_domains_p-1:0] ar_q, ar_d;
    logic                     done_q, done_d;

    // Two's-complement trick isolates the lowest pending domain, so index holes cost nothing.
    logic [num_domains_p-1:0] low_pend;
    logic [num_domains_p-1:0] pend_after;

    assign low_pend   = pend_q & (-pend_q);
    assign pend_after = pend_q & ~low_pend;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            pend_q  <= '1;
            ar_q    <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ar_q    <= ar_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ar_d    = ar_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (v_i && (mask_i != '0)) begin
                    ar_d    = ar_q | mask_i;
                    pend_d  = mask_i;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD, S_GAP: begin
                if (cnt_q == ((state_q == S_HOLD) ? hold_last_lp : gap_last_lp)) begin
                    cnt_d = '0;
                    if (pend_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        ar_d   = ar_q & ~low_pend;
                        pend_d = pend_after;
                        if (pend_after == '0) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_GAP;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + cnt_w_lp'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ready_o       = (state_q == S_IDLE);
        async_reset_o = ar_q;
        done_o        = done_q;
    end

endmodule

// File: tb/tb_bsg_reset_sequencer.sv
// tb/tb_bsg_reset_sequencer.sv - self-checking bench for bsg_reset_sequencer
module tb_bsg_reset_sequencer;

    localparam int N   = 4;
    localparam int H   = 16;
    localparam int G   = 8;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_i;
    logic         a_v, b_v, c_v;
    logic [N-1:0] a_mask;
    logic [2:0]   b_mask;
    logic [0:0]   c_mask;
    logic         a_ready, b_ready, c_ready;
    logic         a_done, b_done, c_done;
    logic [N-1:0] a_ar;
    logic [2:0]   b_ar;
    logic [0:0]   c_ar;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rel_at [N];
    int done_at;

    bsg_reset_sequencer #(.num_domains_p(N), .hold_cycles_p(H), .gap_cycles_p(G)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .v_i(a_v), .mask_i(a_mask),
        .ready_o(a_ready), .async_reset_o(a_ar), .done_o(a_done)
    );

    bsg_reset_sequencer #(.num_domains_p(3), .hold_cycles_p(1), .gap_cycles_p(1)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .v_i(b_v), .mask_i(b_mask),
        .ready_o(b_ready), .async_reset_o(b_ar), .done_o(b_done)
    );

    bsg_reset_sequencer #(.num_domains_p(1), .hold_cycles_p(3), .gap_cycles_p(2)) dut_c (
        .clk_i(clk), .reset_i(reset_i), .v_i(c_v), .mask_i(c_mask),
        .ready_o(c_ready), .async_reset_o(c_ar), .done_o(c_done)
    );

    // Reference: each domain has an absolute release cycle; done is the last release of a sequence.
    task automatic model_init();
        for (int k = 0; k < N; k++) rel_at[k] = H + k * G;
        done_at = H + (N - 1) * G;
    endtask

    task automatic next_cycle();
        int j;
        if (reset_i) begin
            for (int k = 0; k < N; k++) rel_at[k] = BIG;
            done_at = BIG;
        end else if (a_v && (a_mask != '0) && (cyc >= done_at)) begin
            j = 0;
            for (int k = 0; k < N; k++) begin
                if (a_mask[k]) begin
                    rel_at[k] = cyc + 1 + H + j * G;
                    done_at   = rel_at[k];
                    j++;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        a_v = 1'b0; b_v = 1'b0; c_v = 1'b0;
        next_cycle();
        next_cycle();
        reset_i = 1'b0;
        cyc = 0;
        model_init();
    endtask

    // mode 0: idle inputs, 1: random requests, 2: request exactly on the done cycle
    task automatic run_a(input int n, input int mode);
        logic [N-1:0] exp_ar;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < N; k++) exp_ar[k] = (cyc < rel_at[k]);
            checks += 3;
            if (a_ar !== exp_ar) begin
                errors++;
                $display("FAIL async_reset cyc=%0d got=%b exp=%b", cyc, a_ar, exp_ar);
            end
            if (a_done !== (cyc == done_at)) begin
                errors++;
                $display("FAIL done cyc=%0d got=%b exp=%b", cyc, a_done, (cyc == done_at));
            end
            if (a_ready !== (cyc >= done_at)) begin
                errors++;
                $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, a_ready, (cyc >= done_at));
            end
            case (mode)
                1: begin
                    a_v    = ($urandom_range(0, 3) == 0);
                    a_mask = N'($urandom_range(0, (1 << N) - 1));
                end
                2: begin
                    a_v    = (cyc == done_at);
                    a_mask = N'($urandom_range(1, (1 << N) - 1));
                end
                default: begin
                    a_v    = 1'b0;
                    a_mask = '0;
                end
            endcase
            next_cycle();
        end
        a_v = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (a_ar !== 4'hf)    begin errors++; $display("FAIL reset_ar got=%b exp=1111", a_ar); end
        if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", a_ready); end
        if (a_done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", a_done); end
        if (b_ar !== 3'b111)  begin errors++; $display("FAIL reset_b_ar got=%b exp=111", b_ar); end
        if (c_ar !== 1'b1)    begin errors++; $display("FAIL reset_c_ar got=%b exp=1", c_ar); end
    endtask

    task automatic test_power_on();
        run_a(45, 0);
    endtask

    task automatic test_sparse();
        a_v = 1'b1;
        a_mask = 4'b1010;
        next_cycle();
        a_v = 1'b0;
        checks += 2;
        if (a_ar !== 4'b1010) begin errors++; $display("FAIL sparse_set got=%b exp=1010", a_ar); end
        if (a_ready !== 1'b0) begin errors++; $display("FAIL sparse_busy got=%b exp=0", a_ready); end
        run_a(30, 0);
    endtask

    task automatic test_zero_and_busy();
        a_v = 1'b1;
        a_mask = 4'b0000;
        next_cycle();
        checks += 3;
        if (a_ar !== 4'b0000) begin errors++; $display("FAIL zero_mask_ar got=%b exp=0000", a_ar); end
        if (a_ready !== 1'b1) begin errors++; $display("FAIL zero_mask_ready got=%b exp=1", a_ready); end
        if (a_done !== 1'b0)  begin errors++; $display("FAIL zero_mask_done got=%b exp=0", a_done); end
        a_mask = 4'b1100;
        next_cycle();
        a_v = 1'b0;
        run_a(19, 0);
        a_v = 1'b1;
        a_mask = 4'b0001;
        next_cycle();
        a_v = 1'b0;
        checks += 1;
        if (a_ar[0] !== 1'b0) begin errors++; $display("FAIL busy_ignored got=%b exp=0", a_ar[0]); end
        run_a(12, 0);
    endtask

    task automatic test_mid_reset();
        do_reset();
        run_a(20, 0);
        reset_i = 1'b1;
        next_cycle();
        checks += 2;
        if (a_ar !== 4'hf)    begin errors++; $display("FAIL mid_reset_ar got=%b exp=1111", a_ar); end
        if (a_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got=%b exp=0", a_ready); end
        reset_i = 1'b0;
        cyc = 0;
        model_init();
        run_a(45, 0);
    endtask

    task automatic test_back_to_back();
        run_a(300, 2);
    endtask

    task automatic test_random();
        run_a(800, 1);
        run_a(60, 0);
    endtask

    task automatic test_min_intervals();
        logic [2:0] b_ar_tab    [8] = '{3'b111, 3'b110, 3'b100, 3'b000, 3'b101, 3'b100, 3'b000, 3'b000};
        logic       b_done_tab  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       b_ready_tab [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       c_ar_tab    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       c_done_tab  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        b_mask = 3'b101;
        c_mask = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks += 5;
            if (b_ar !== b_ar_tab[i]) begin
                errors++; $display("FAIL min_ar cyc=%0d got=%b exp=%b", i, b_ar, b_ar_tab[i]);
            end
            if (b_done !== b_done_tab[i]) begin
                errors++; $display("FAIL min_done cyc=%0d got=%b exp=%b", i, b_done, b_done_tab[i]);
            end
            if (b_ready !== b_ready_tab[i]) begin
                errors++; $display("FAIL min_ready cyc=%0d got=%b exp=%b", i, b_ready, b_ready_tab[i]);
            end
            if (c_ar !== c_ar_tab[i]) begin
                errors++; $display("FAIL single_ar cyc=%0d got=%b exp=%b", i, c_ar, c_ar_tab[i]);
            end
            if (c_done !== c_done_tab[i]) begin
                errors++; $display("FAIL single_done cyc=%0d got=%b exp=%b", i, c_done, c_done_tab[i]);
            end
            b_v = (i == 3);
            next_cycle();
        end
        b_v = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        a_v = 1'b0; a_mask = '0;
        b_v = 1'b0; b_mask = '0;
        c_v = 1'b0; c_mask = '0;
        @(negedge clk);
        test_reset();
        test_power_on();
        test_sparse();
        test_zero_and_busy();
        test_mid_reset();
        test_back_to_back();
        test_random();
        test_min_intervals();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsg_reset_sequencer.md
# bsg_reset_sequencer

Drives the asynchronous-reset inputs of up to `num_domains_p` downstream register domains, such as banks of async-reset flops. At power-on it holds every domain in reset and then releases them one at a time in ascending index order, with programmable hold and spacing intervals. After that, requesters can re-reset any subset of domains through a valid/ready port, and those domains are released with the same staged timing. It sits in the clock/reset infrastructure between the chip-level synchronous reset and the per-domain `async_reset_i` pins.

## Interface
- `num_domains_p`, default 4: number of controlled reset domains; must be ≥ 1.
- `hold_cycles_p`, default 16: cycles every selected domain stays in reset before the first release; must be ≥ 1.
- `gap_cycles_p`, default 8: cycles between consecutive domain releases; must be ≥ 1.
- `clk_i`  input  1  clock.
- `reset_i`  input  1  reset, synchronous, active-high.
- `v_i`  input  1  re-reset request valid.
- `mask_i`  input  `num_domains_p`  domains to re-reset; bit k selects domain k.
- `ready_o`  output  1  sequencer is idle and will accept a request.
- `async_reset_o`  output  `num_domains_p`  per-domain reset, active-high, driven straight from a flop (glitch-free); bit k drives domain k.
- `done_o`  output  1  one-cycle pulse when a sequence completes.

## Operation
States: IDLE, HOLD, GAP.

**Reset (`reset_i` = 1)**
- Takes priority over all other activity, in any state.
- Next cycle outputs: `async_reset_o` = all ones, `ready_o` = 0, `done_o` = 0.
- Pending set = all domains; state = HOLD, with the hold counter restarted.
- Asserting `reset_i` mid-sequence abandons that sequence and starts a full power-on sequence.

**HOLD**
- Counts `hold_cycles_p` cycles.
- At the end, releases the lowest-index pending domain, removes it from the pending set, and moves to GAP.
- If nothing remains pending, moves to IDLE instead.

**GAP**
- Counts `gap_cycles_p` cycles.
- At the end, releases the next lowest-index pending domain.
- Repeats until the pending set is empty, then moves to IDLE.

**Common rules**
- Non-selected domains are skipped with no time cost: releases of selected domains are exactly `gap_cycles_p` apart regardless of index holes.

**IDLE**
- `ready_o` = 1.
- Accept on `v_i & ready_o & (mask_i != 0)`:
  - `async_reset_o |= mask_i`; pending set = `mask_i`; state = HOLD.
  - Unselected bits of `async_reset_o` are unchanged.
- `v_i` with `mask_i == 0` is ignored: no state change, no `done_o`.
- While not IDLE, `v_i` and `mask_i` are ignored.

**Completion**
- `done_o` and `ready_o` rise in the same cycle the last release becomes visible on `async_reset_o`.
- `done_o` lasts one cycle.
- A new request may be accepted in that same cycle (back-to-back operation).

**Counters**
- Width is `$clog2(max(hold_cycles_p, gap_cycles_p) + 1)`.
- Must not wrap; `hold_cycles_p` = `gap_cycles_p` = 1 is legal.

## Timing
**Cycle reference:** cycle 0 is the first cycle `reset_i` is sampled low after reset.

**Power-on release**
- The k-th released domain (k = 0..`num_domains_p`-1) reads `async_reset_o[k]` = 0 starting at cycle `hold_cycles_p + k*gap_cycles_p`.
- `done_o` = 1 exactly at cycle `hold_cycles_p + (num_domains_p-1)*gap_cycles_p`.

**Request**
- Request accepted at cycle t:
  - Selected bits read 1 from cycle t+1.
  - `ready_o` = 0 from cycle t+1.
- The j-th selected domain (ascending index) reads 0 from cycle `t+1+hold_cycles_p+j*gap_cycles_p`.
- `done_o` fires at the last such cycle.

**Output timing**
- All outputs are registered; no combinational path from inputs to outputs.
- `ready_o` depends on state only.

**Reset values:** `async_reset_o` = all ones, `ready_o` = 0, `done_o` = 0.

## Test plan
- **Power-on** (N=4, hold=16, gap=8): deassert `reset_i` at cycle 0 → bits 0,1,2,3 fall at cycles 16, 24, 32, 40; `done_o` only at 40; `ready_o` = 1 from 40.
- **Sparse request:** from IDLE, `v_i` = 1, `mask_i` = 4'b1010 accepted at cycle t → bits 1 and 3 high at t+1, bits 0 and 2 stay 0; bit 1 low at t+17, bit 3 low at t+25; `done_o` at t+25.
- **Zero-mask and busy requests:** `v_i` = 1 with `mask_i` = 0 in IDLE → no output change, no `done_o`. `v_i` = 1 with mask 4'b0001 during GAP → ignored; bit 0 stays 0.
- **Reset mid-sequence:** assert `reset_i` for one cycle during the GAP after bit 0 released → all bits 1 next cycle; full power-on timing restarts from the reset-deassert cycle.
- **Minimum intervals** (hold=1, gap=1, N=3): bits fall at cycles 1, 2, 3; `done_o` at cycle 3. A request accepted at cycle 3 (same cycle as `done_o`) is honoured.
- **Single domain** (N=1): power-on releases at cycle `hold_cycles_p`, with `done_o` in the same cycle.
